// File: rtl/rota_pkg.sv
// Shared definitions for the serial rotator: FSM state encoding and default width.
package rota_pkg;

  localparam int ANCHO_DEF = 8;

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    ROTANDO = 2'd1,
    LISTO   = 2'd2
  } estado_t;

endpackage

// File: rtl/rota_inversa_serie_if.sv
// Handshake/data bundle of the serial rotator.
// Optional macro ROTA_DIRECCION_EN adds the Direccion request signal.
interface rota_inversa_serie_if #(
  parameter int ANCHO    = rota_pkg::ANCHO_DEF,
  parameter int CUENTA_W = $clog2(ANCHO)
);
  logic                Inicio;
  logic [ANCHO-1:0]    Entrada;
  logic [CUENTA_W-1:0] Cantidad;
`ifdef ROTA_DIRECCION_EN
  logic                Direccion;
`endif
  logic [ANCHO-1:0]    Salida;
  logic                Ocupado;
  logic                Listo;

`ifdef ROTA_DIRECCION_EN
  modport master (output Inicio, Entrada, Cantidad, Direccion,
                  input  Salida, Ocupado, Listo);
  modport slave  (input  Inicio, Entrada, Cantidad, Direccion,
                  output Salida, Ocupado, Listo);
`else
  modport master (output Inicio, Entrada, Cantidad,
                  input  Salida, Ocupado, Listo);
  modport slave  (input  Inicio, Entrada, Cantidad,
                  output Salida, Ocupado, Listo);
`endif
endinterface

// File: rtl/rota_un_paso.sv
// One-position combinational rotation.
// Default: MSB wraps into LSB. With ROTA_DIRECCION_EN, direccion=1 rotates
// the other way (LSB wraps into MSB).
module rota_un_paso #(
  parameter int ANCHO = rota_pkg::ANCHO_DEF
) (
`ifdef ROTA_DIRECCION_EN
  input  logic             direccion,
`endif
  input  logic [ANCHO-1:0] dato,
  output logic [ANCHO-1:0] rotado
);

  // Select the rotated word for the requested direction.
  always_comb begin
    rotado = {dato[ANCHO-2:0], dato[ANCHO-1]};
`ifdef ROTA_DIRECCION_EN
    if (direccion) begin
      rotado = {dato[0], dato[ANCHO-1:1]};
    end else begin
      rotado = {dato[ANCHO-2:0], dato[ANCHO-1]};
    end
`endif
  end

endmodule

// File: rtl/rota_inversa_serie.sv
// Serial rotator: captures Entrada/Cantidad on an accepted Inicio, rotates one
// position per cycle, then publishes the result on Salida with a Listo pulse.
// Optional macro ROTA_DIRECCION_EN enables the Direccion input.
module rota_inversa_serie
  import rota_pkg::*;
#(
  parameter int ANCHO    = ANCHO_DEF,
  parameter int CUENTA_W = $clog2(ANCHO)
) (
  input logic                  Reloj,
  input logic                  Reset_n,
  rota_inversa_serie_if.slave  bus
);

  estado_t             estado_r;
  estado_t             estado_s;
  logic                acepta_s;
  logic                ocupado_s;
  logic                listo_s;
  logic                ocupado_r;
  logic                listo_r;
  logic [ANCHO-1:0]    dato_r;
  logic [ANCHO-1:0]    rotado_s;
  logic [ANCHO-1:0]    salida_r;
  logic [CUENTA_W-1:0] restante_r;
`ifdef ROTA_DIRECCION_EN
  logic                direccion_r;
`endif

  rota_un_paso #(.ANCHO(ANCHO)) u_paso (
`ifdef ROTA_DIRECCION_EN
    .direccion (direccion_r),
`endif
    .dato      (dato_r),
    .rotado    (rotado_s)
  );

  // A start is taken only when not rotating (idle or the result cycle).
  always_comb begin
    acepta_s = bus.Inicio && ((estado_r == REPOSO) || (estado_r == LISTO));
  end

  // State register.
  always_ff @(posedge Reloj or negedge Reset_n) begin
    if (!Reset_n) begin
      estado_r <= REPOSO;
    end else begin
      estado_r <= estado_s;
    end
  end

  // Next-state logic.
  always_comb begin
    estado_s = estado_r;
    case (estado_r)
      REPOSO: begin
        if (bus.Inicio) estado_s = ROTANDO;
        else            estado_s = REPOSO;
      end
      ROTANDO: begin
        if (restante_r == {CUENTA_W{1'b0}}) estado_s = LISTO;
        else                                estado_s = ROTANDO;
      end
      LISTO: begin
        if (bus.Inicio) estado_s = ROTANDO;
        else            estado_s = REPOSO;
      end
      default: estado_s = REPOSO;
    endcase
  end

  // Status decode from the next state so the registered flags line up with it.
  always_comb begin
    ocupado_s = (estado_s == ROTANDO);
    listo_s   = (estado_s == LISTO);
  end

  // Registered status flags.
  always_ff @(posedge Reloj or negedge Reset_n) begin
    if (!Reset_n) begin
      ocupado_r <= 1'b0;
      listo_r   <= 1'b0;
    end else begin
      ocupado_r <= ocupado_s;
      listo_r   <= listo_s;
    end
  end

  // Operand capture, per-cycle rotation and result publication.
  always_ff @(posedge Reloj or negedge Reset_n) begin
    if (!Reset_n) begin
      dato_r      <= {ANCHO{1'b0}};
      restante_r  <= {CUENTA_W{1'b0}};
      salida_r    <= {ANCHO{1'b0}};
`ifdef ROTA_DIRECCION_EN
      direccion_r <= 1'b0;
`endif
    end else if (acepta_s) begin
      dato_r      <= bus.Entrada;
      restante_r  <= bus.Cantidad;
`ifdef ROTA_DIRECCION_EN
      direccion_r <= bus.Direccion;
`endif
    end else if (estado_r == ROTANDO) begin
      if (restante_r != {CUENTA_W{1'b0}}) begin
        dato_r     <= rotado_s;
        restante_r <= restante_r - CUENTA_W'(1);
      end else begin
        // Final cycle: Dato holds still and becomes the visible result.
        salida_r   <= dato_r;
      end
    end
  end

  assign bus.Salida  = salida_r;
  assign bus.Ocupado = ocupado_r;
  assign bus.Listo   = listo_r;

endmodule

// File: tb/tb_rota_inversa_serie.sv
// Self-checking bench for rota_inversa_serie (8-bit build).
// Honours ROTA_DIRECCION_EN when the macro is defined for the build.
module tb_rota_inversa_serie;

  logic Reloj;
  logic Reset_n;
  int   checks;
  int   errors;
  logic [7:0] last_result;

  rota_inversa_serie_if #(.ANCHO(8), .CUENTA_W(3)) bus ();

  rota_inversa_serie #(.ANCHO(8), .CUENTA_W(3)) dut (
    .Reloj   (Reloj),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  initial Reloj = 1'b0;
  always #5 Reloj = ~Reloj;

  // Reference: rotation of x by c places; dir=0 moves bits towards the MSB.
  function automatic logic [7:0] rot_ref(input logic [7:0] x, input int c, input bit dir);
    logic [15:0] d;
    d = {x, x};
    if (dir) d = d >> c;
    else     d = d >> (8 - c);
    return d[7:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Reloj);
    #1;
  endtask

  task automatic set_dir(input bit dir);
`ifdef ROTA_DIRECCION_EN
    bus.Direccion = dir;
`else
    if (dir) $display("note: direction request ignored in this build");
`endif
  endtask

  // One operation: assert Inicio for one edge, then follow it to Listo.
  task automatic run_op(input logic [7:0] ent, input int cant, input bit dir,
                        input bit interfere, input logic [7:0] exp, input string tag);
    int  n;
    int  busy;
    bit  seen;
    bit  held_ok;
    bus.Inicio   = 1'b1;
    bus.Entrada  = ent;
    bus.Cantidad = 3'(cant);
    set_dir(dir);
    step();
    check({tag, "_ocupado_acc"}, 32'(bus.Ocupado), 32'd1);
    check({tag, "_listo_acc"}, 32'(bus.Listo), 32'd0);
    busy    = 1;
    n       = 0;
    seen    = 1'b0;
    held_ok = 1'b1;
    while (!seen && n < 40) begin
      if (interfere && n == 0) begin
        bus.Inicio   = 1'b1;
        bus.Entrada  = 8'hFF;
        bus.Cantidad = 3'd0;
      end else begin
        bus.Inicio   = 1'b0;
        bus.Entrada  = 8'($urandom);
        bus.Cantidad = 3'($urandom);
      end
      step();
      n++;
      if (bus.Listo === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (bus.Ocupado === 1'b1) busy++;
        if (bus.Salida !== last_result) held_ok = 1'b0;
      end
    end
    bus.Inicio = 1'b0;
    check({tag, "_latencia"}, 32'(n), 32'(cant + 1));
    check({tag, "_ciclos_ocupado"}, 32'(busy), 32'(cant + 1));
    check({tag, "_salida_estable"}, 32'(held_ok), 32'd1);
    check({tag, "_ocupado_listo"}, 32'(bus.Ocupado), 32'd0);
    check({tag, "_salida"}, 32'(bus.Salida), 32'(exp));
    last_result = exp;
  endtask

  // One idle cycle: the Listo pulse must be over and the block idle.
  task automatic idle(input string tag);
    bus.Inicio = 1'b0;
    step();
    check({tag, "_listo_fin"}, 32'(bus.Listo), 32'd0);
    check({tag, "_ocupado_fin"}, 32'(bus.Ocupado), 32'd0);
  endtask

  initial begin
    int  pulses;
    int  c;
    bit  d;
    logic [7:0] e;
    checks       = 0;
    errors       = 0;
    last_result  = 8'h00;
    Reset_n      = 1'b0;
    bus.Inicio   = 1'b0;
    bus.Entrada  = 8'h00;
    bus.Cantidad = 3'd0;
    set_dir(1'b0);

    // Reset state.
    step();
    step();
    check("reset_salida", 32'(bus.Salida), 32'h0);
    check("reset_ocupado", 32'(bus.Ocupado), 32'd0);
    check("reset_listo", 32'(bus.Listo), 32'd0);

    // Release reset and start on the very first edge.
    Reset_n = 1'b1;
    run_op(8'hB4, 2, 1'b0, 1'b0, 8'hD2, "b4_c2");
    idle("b4_c2");
    run_op(8'hB4, 0, 1'b0, 1'b0, 8'hB4, "b4_c0");
    idle("b4_c0");

    // Maximum count, then a back-to-back start held during LISTO.
    run_op(8'h01, 7, 1'b0, 1'b0, 8'h80, "01_c7");
    run_op(8'h80, 1, 1'b0, 1'b0, 8'h01, "80_c1_b2b");
    idle("80_c1_b2b");

    // Inicio during rotation is ignored.
    run_op(8'hB4, 3, 1'b0, 1'b1, 8'hA5, "ignora");
    idle("ignora");

`ifdef ROTA_DIRECCION_EN
    run_op(8'h01, 1, 1'b1, 1'b0, 8'h80, "dir1");
    idle("dir1");
    run_op(8'h01, 1, 1'b0, 1'b0, 8'h02, "dir0");
    idle("dir0");
`endif

    // Reset in the middle of a rotation.
    bus.Inicio   = 1'b1;
    bus.Entrada  = 8'h3C;
    bus.Cantidad = 3'd5;
    step();
    bus.Inicio = 1'b0;
    step();
    check("mid_ocupado_antes", 32'(bus.Ocupado), 32'd1);
    Reset_n = 1'b0;
    #1;
    check("mid_salida_rst", 32'(bus.Salida), 32'h0);
    check("mid_ocupado_rst", 32'(bus.Ocupado), 32'd0);
    check("mid_listo_rst", 32'(bus.Listo), 32'd0);
    step();
    Reset_n = 1'b1;
    last_result = 8'h00;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.Listo !== 1'b0 || bus.Ocupado !== 1'b0) pulses++;
    end
    check("mid_sin_listo", 32'(pulses), 32'd0);
    check("mid_salida_tras", 32'(bus.Salida), 32'h0);

    // Randomized operations against the reference, some back-to-back.
    for (int i = 0; i < 30; i++) begin
      e = 8'($urandom);
      c = int'($urandom_range(7, 0));
`ifdef ROTA_DIRECCION_EN
      d = 1'($urandom);
`else
      d = 1'b0;
`endif
      run_op(e, c, d, 1'b0, rot_ref(e, c, d), $sformatf("rnd%0d", i));
      if ($urandom_range(1, 0) == 0) idle($sformatf("rnd%0d", i));
    end
    idle("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
